// File: rtl/commit_flush_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | commit_flush_ctrl: misprediction recovery sequencer at the ROB head.        |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module commit_flush_ctrl #(
  parameter int RESTORE_CYCLES = 1,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rob_head_valid,
  input  logic                 rob_head_ready,
  input  logic [6:0]           rob_head_opcode,
  input  logic                 rob_head_mispredict,
  input  logic [31:0]          rob_head_target,
  input  logic                 dmem_busy,
  output logic                 flush_branch,
  output logic                 move_flush,
  output logic                 flush_all,
  output logic                 rat_restore,
  output logic                 pc_redirect_valid,
  output logic [31:0]          pc_redirect_addr,
  output logic                 frontend_stall,
  output logic [CNT_WIDTH-1:0] flush_count
);

  localparam logic [6:0] c_op_jal  = 7'b1101111;
  localparam logic [6:0] c_op_jalr = 7'b1100111;
  localparam logic [6:0] c_op_br   = 7'b1100011;
  localparam logic [3:0] c_restore_load = 4'(RESTORE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] c_cnt_max = {CNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DRAIN   = 2'd1,
    S_COMMIT  = 2'd2,
    S_RESTORE = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [31:0]            r_target;
  logic [31:0]            r_redirect;
  logic [3:0]             r_rcnt;
  logic [CNT_WIDTH-1:0]   r_count;
  logic                   w_is_cf;
  logic                   w_detect;

  assign w_is_cf  = (rob_head_opcode == c_op_jal) || (rob_head_opcode == c_op_jalr) ||
                    (rob_head_opcode == c_op_br);
  // Gated by rst so the IDLE outputs also read 0 while reset is held.
  assign w_detect = !rst && (r_state == S_IDLE) && rob_head_valid && rob_head_ready &&
                    rob_head_mispredict && w_is_cf;

  always_comb begin
    w_next            = r_state;
    flush_branch      = 1'b0;
    move_flush        = 1'b0;
    flush_all         = 1'b0;
    rat_restore       = 1'b0;
    pc_redirect_valid = 1'b0;
    frontend_stall    = 1'b0;
    case (r_state)
      S_IDLE: begin
        flush_branch   = w_detect;
        frontend_stall = w_detect;
        if (w_detect) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        flush_branch   = 1'b1;
        frontend_stall = 1'b1;
        if (!dmem_busy) w_next = S_COMMIT;
      end
      S_COMMIT: begin
        flush_branch      = 1'b1;
        move_flush        = 1'b1;
        flush_all         = 1'b1;
        rat_restore       = 1'b1;
        pc_redirect_valid = 1'b1;
        frontend_stall    = 1'b1;
        w_next            = S_RESTORE;
      end
      S_RESTORE: begin
        frontend_stall = 1'b1;
        if (r_rcnt == 4'd0) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_target   <= 32'd0;
      r_redirect <= 32'd0;
      r_rcnt     <= 4'd0;
      r_count    <= '0;
    end else begin
      r_state <= w_next;
      if (w_detect) r_target <= rob_head_target;
      // Redirect register only changes on entry to COMMIT, so it holds its value elsewhere.
      if (r_state == S_DRAIN && !dmem_busy) r_redirect <= r_target;
      if (r_state == S_COMMIT) begin
        r_rcnt <= c_restore_load;
        if (r_count != c_cnt_max) r_count <= r_count + CNT_WIDTH'(1);
      end else if (r_state == S_RESTORE && r_rcnt != 4'd0) begin
        r_rcnt <= r_rcnt - 4'd1;
      end
    end
  end

  assign pc_redirect_addr = r_redirect;
  assign flush_count      = r_count;

endmodule
`default_nettype wire

// File: tb/tb_commit_flush_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_commit_flush_ctrl: scoreboard bench, two instances (R=1/W=2, R=3/W=16).  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_commit_flush_ctrl;

  localparam logic [6:0] c_jal   = 7'b1101111;
  localparam logic [6:0] c_jalr  = 7'b1100111;
  localparam logic [6:0] c_br    = 7'b1100011;
  localparam logic [6:0] c_store = 7'b0100011;

  logic        clk, rst;
  logic        valid, ready, mispred, busy, sel;
  logic [6:0]  opcode;
  logic [31:0] target;

  logic        a_fb, a_mf, a_fa, a_rr, a_pv, a_st;
  logic [31:0] a_addr;
  logic [1:0]  a_cnt;
  logic        b_fb, b_mf, b_fa, b_rr, b_pv, b_st;
  logic [31:0] b_addr;
  logic [15:0] b_cnt;

  commit_flush_ctrl #(.RESTORE_CYCLES(1), .CNT_WIDTH(2)) dut_a (
    .clk(clk), .rst(rst),
    .rob_head_valid(valid & ~sel), .rob_head_ready(ready), .rob_head_opcode(opcode),
    .rob_head_mispredict(mispred), .rob_head_target(target), .dmem_busy(busy),
    .flush_branch(a_fb), .move_flush(a_mf), .flush_all(a_fa), .rat_restore(a_rr),
    .pc_redirect_valid(a_pv), .pc_redirect_addr(a_addr), .frontend_stall(a_st),
    .flush_count(a_cnt)
  );

  commit_flush_ctrl #(.RESTORE_CYCLES(3), .CNT_WIDTH(16)) dut_b (
    .clk(clk), .rst(rst),
    .rob_head_valid(valid & sel), .rob_head_ready(ready), .rob_head_opcode(opcode),
    .rob_head_mispredict(mispred), .rob_head_target(target), .dmem_busy(busy),
    .flush_branch(b_fb), .move_flush(b_mf), .flush_all(b_fa), .rat_restore(b_rr),
    .pc_redirect_valid(b_pv), .pc_redirect_addr(b_addr), .frontend_stall(b_st),
    .flush_count(b_cnt)
  );

  typedef struct packed {
    logic        sel;
    logic        fb, mf, fa, rr, pv, st;
    logic [31:0] addr;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] exp_addr [2];
  logic [15:0] exp_cnt  [2];
  int          n_checks = 0;
  int          n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Expected value for the cycle just driven; then advance to the next drive point.
  task automatic tick(input logic fb, mf, fa, rr, pv, st);
    exp_t e;
    e.sel = sel; e.fb = fb; e.mf = mf; e.fa = fa; e.rr = rr; e.pv = pv; e.st = st;
    e.addr = exp_addr[sel];
    e.cnt  = exp_cnt[sel];
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 0);
  endtask

  task automatic clear_head();
    valid = 1'b0; ready = 1'b0; mispred = 1'b0; opcode = 7'd0;
  endtask

  task automatic reset_model();
    exp_addr[0] = 32'd0; exp_addr[1] = 32'd0;
    exp_cnt[0]  = 16'd0; exp_cnt[1]  = 16'd0;
  endtask

  // Full sequence; the head stays asserted afterwards so the caller can chain another.
  task automatic flush(input logic [6:0] op, input logic [31:0] tgt, input int busy_n);
    int          r;
    logic [15:0] cmax;
    r    = sel ? 3 : 1;
    cmax = sel ? 16'hFFFF : 16'h0003;
    valid = 1'b1; ready = 1'b1; mispred = 1'b1; opcode = op; target = tgt; busy = 1'b0;
    tick(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < busy_n; i++) begin
      busy = 1'b1; target = ~tgt;
      tick(1, 0, 0, 0, 0, 1);
    end
    busy = 1'b0; target = tgt ^ 32'h5A5A_0000;
    tick(1, 0, 0, 0, 0, 1);
    busy = 1'b1;
    exp_addr[sel] = tgt;
    tick(1, 1, 1, 1, 1, 1);
    if (exp_cnt[sel] != cmax) exp_cnt[sel] = exp_cnt[sel] + 16'd1;
    for (int i = 0; i < r; i++) begin
      busy = i[0];
      tick(0, 0, 0, 0, 0, 1);
    end
    busy = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    #3;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (!e.sel) begin
        chk("flush_branch", {31'd0, a_fb}, {31'd0, e.fb});
        chk("move_flush",   {31'd0, a_mf}, {31'd0, e.mf});
        chk("flush_all",    {31'd0, a_fa}, {31'd0, e.fa});
        chk("rat_restore",  {31'd0, a_rr}, {31'd0, e.rr});
        chk("pc_valid",     {31'd0, a_pv}, {31'd0, e.pv});
        chk("stall",        {31'd0, a_st}, {31'd0, e.st});
        chk("pc_addr",      a_addr, e.addr);
        chk("flush_count",  {30'd0, a_cnt}, {16'd0, e.cnt});
      end else begin
        chk("flush_branch", {31'd0, b_fb}, {31'd0, e.fb});
        chk("move_flush",   {31'd0, b_mf}, {31'd0, e.mf});
        chk("flush_all",    {31'd0, b_fa}, {31'd0, e.fa});
        chk("rat_restore",  {31'd0, b_rr}, {31'd0, e.rr});
        chk("pc_valid",     {31'd0, b_pv}, {31'd0, e.pv});
        chk("stall",        {31'd0, b_st}, {31'd0, e.st});
        chk("pc_addr",      b_addr, e.addr);
        chk("flush_count",  {16'd0, b_cnt}, {16'd0, e.cnt});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; sel = 1'b0; busy = 1'b0; target = 32'd0;
    clear_head();
    reset_model();
    @(negedge clk);
    idle(2);
    rst = 1'b0;
    idle(2);

    // Correctly predicted branch, unfinished head, and non-control-flow mispredict
    valid = 1'b1; ready = 1'b1; opcode = c_br; mispred = 1'b0;
    idle(3);
    ready = 1'b0; mispred = 1'b1;
    idle(1);
    ready = 1'b1; opcode = c_store;
    busy = 1'b1;
    idle(2);
    busy = 1'b0;
    clear_head();
    idle(1);

    // Instance A: jalr, no drain wait
    flush(c_jalr, 32'h0000_1234, 0);
    clear_head();
    idle(2);

    // Instance B: drain wait of 4 cycles, target disturbed during DRAIN
    sel = 1'b1;
    idle(1);
    flush(c_br, 32'hABCD_0040, 4);
    clear_head();
    idle(1);
    flush(c_jal, 32'h0000_8000, 0);
    clear_head();
    idle(2);

    // Reset during DRAIN, head kept asserted while rst is high
    valid = 1'b1; ready = 1'b1; mispred = 1'b1; opcode = c_jal; target = 32'h0000_4444;
    tick(1, 0, 0, 0, 0, 1);
    rst = 1'b1;
    reset_model();
    idle(1);
    rst = 1'b0;
    clear_head();
    idle(3);

    // Reset during COMMIT
    valid = 1'b1; ready = 1'b1; mispred = 1'b1; opcode = c_br; target = 32'h0000_5550;
    tick(1, 0, 0, 0, 0, 1);
    tick(1, 0, 0, 0, 0, 1);
    rst = 1'b1;
    reset_model();
    idle(1);
    rst = 1'b0;
    clear_head();
    idle(3);

    // Instance A: five back-to-back flushes, 2-bit counter saturates
    sel = 1'b0;
    idle(1);
    for (int k = 0; k < 5; k++) flush(c_jal, 32'h0000_1000 + 32'(k * 16), 0);
    clear_head();
    idle(2);

    @(negedge clk);
    #5;
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/commit_flush_ctrl.md
# commit_flush_ctrl

Sequencer for branch/jump misprediction recovery at the ROB head. When a mispredicted `jal`/`jalr`/`br` reaches commit, it:

- holds the head entry by asserting `flush_branch` with `move_flush` low;
- waits for outstanding data-memory traffic to drain;
- in a single cycle, pops the head entry and fires the global flush, RAT restore and PC redirect;
- stalls the frontend for a programmable recovery window.

It drives the `flush_branch`/`move_flush` pair consumed by the commit stage and sits between the ROB head, the data-memory interface and the fetch unit.

## Interface
- RESTORE_CYCLES, 1, cycles spent in RESTORE after the flush pulse; legal range is 1..15.
- CNT_WIDTH, 16, width of the saturating flush counter.

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- rob_head_valid  in  1  ROB head entry present
- rob_head_ready  in  1  ROB head entry finished executing
- rob_head_opcode  in  7  opcode of head entry
- rob_head_mispredict  in  1  head control-flow op resolved opposite to its prediction
- rob_head_target  in  32  correct next PC of head op
- dmem_busy  in  1  data-memory transaction outstanding whose response must be absorbed
- flush_branch  out  1  flush sequence in progress (to commit)
- move_flush  out  1  commit may pop the mispredicted head (to commit)
- flush_all  out  1  one-cycle pulse: clear ROB, reservation stations, queues
- rat_restore  out  1  one-cycle pulse: copy retirement RAT into speculative RAT
- pc_redirect_valid  out  1  one-cycle pulse: load fetch PC
- pc_redirect_addr  out  32  redirect target (registered)
- frontend_stall  out  1  fetch/dispatch must not advance
- flush_count  out  CNT_WIDTH  completed flushes, saturating

## Operation
- Opcodes:
  - `jal` = 7'b1101111
  - `jalr` = 7'b1100111
  - `br` = 7'b1100011
- detect = !rst && state==IDLE && rob_head_valid && rob_head_ready && rob_head_mispredict && opcode ∈ {jal, jalr, br}.
- `rob_head_mispredict` on any other opcode is ignored.
- States: IDLE, DRAIN, COMMIT, RESTORE.
- IDLE:
  - outputs low, except that `flush_branch` and `frontend_stall` equal detect (combinational).
  - On detect: latch `rob_head_target` into the target register; next state is DRAIN.
- DRAIN:
  - `flush_branch` = 1, `frontend_stall` = 1, `move_flush` = 0.
  - If `dmem_busy` = 0 → COMMIT; otherwise stay in DRAIN.
- COMMIT (exactly one cycle):
  - `flush_branch`, `move_flush`, `flush_all`, `rat_restore`, `pc_redirect_valid`, `frontend_stall` all = 1.
  - `pc_redirect_addr` = latched target.
  - `flush_count` increments at the end of the cycle, saturating at all-ones.
  - Load restore counter with RESTORE_CYCLES−1; next state is RESTORE.
- RESTORE:
  - `frontend_stall` = 1; all other pulses are 0.
  - Decrement the counter; when it reaches 0 → IDLE.
- ROB head inputs are ignored outside IDLE. The head is held stable because no pop occurs before COMMIT.
- `pc_redirect_addr` holds its last value outside COMMIT. Consumers qualify it with `pc_redirect_valid`.

## Timing
- Reset (asynchronous, immediate):
  - state = IDLE; target register = 0; restore counter = 0; `flush_count` = 0.
  - All outputs read 0.
- Reset mid-sequence aborts without emitting any pulse, including when asserted during COMMIT.
- Latency:
  - Detect at cycle T.
  - DRAIN at T+1. If `dmem_busy` = 0 at T+1, COMMIT is at T+2.
  - RESTORE occupies T+3 .. T+2+RESTORE_CYCLES.
  - IDLE at T+3+RESTORE_CYCLES. A new detect is possible in that cycle.
- Each cycle of `dmem_busy` = 1 observed in DRAIN adds one cycle before COMMIT.
- `move_flush` is high for exactly one cycle per flush. It never asserts without `flush_branch`.
- `flush_all`, `rat_restore` and `pc_redirect_valid` are coincident with `move_flush`.
- `dmem_busy` toggling in IDLE, COMMIT or RESTORE has no effect.
- At saturation, `flush_count` holds all-ones; further flushes still complete normally.

## Test plan
- Non-mispredicted `br` at the head (valid = ready = 1, mispredict = 0):
  - `flush_branch` stays 0 and the state stays IDLE.
- Mispredicted `jalr`, target 0x0000_1234, `dmem_busy` = 0, RESTORE_CYCLES = 1:
  - `flush_branch` high at T..T+2; `move_flush`/`flush_all`/`rat_restore`/`pc_redirect_valid` high only at T+2.
  - `pc_redirect_addr` = 0x1234; `frontend_stall` high T..T+3; `flush_count` = 1.
- Mispredicted `br` with `dmem_busy` held high for 4 cycles from T+1:
  - COMMIT at T+6; `move_flush` stays low through T+5.
  - `rob_head_target` changed during DRAIN does not alter the redirect address.
- `rob_head_mispredict` = 1 with opcode = store (7'b0100011):
  - No detect and no outputs asserted.
- Reset asserted in DRAIN and again in COMMIT:
  - All outputs drop immediately; `flush_count` = 0; no pulses after rst deasserts.
- CNT_WIDTH = 2, five back-to-back flushes:
  - `flush_count` reads 1, 2, 3, 3, 3.
  - The second detect occurs in the first IDLE cycle after RESTORE.
